// File: rtl/ddr_stim_sequencer_if.sv
// Request-side bundle between the stimulus sequencer (master) and the DDR controller bench (slave).
interface ddr_stim_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              start;
   logic              dev_busy;
   logic              next_cmd;
   logic              act_cmd;
   logic [ADDR_W-1:0] physical_addr;
   logic [DATA_W-1:0] data_wr;
   logic              rw;
   logic [15:0]       cmd_count;
   logic              done;
   logic              error;

   modport master (
      input  start, dev_busy, next_cmd,
      output act_cmd, physical_addr, data_wr, rw, cmd_count, done, error
   );

   modport slave (
      output start, dev_busy, next_cmd,
      input  act_cmd, physical_addr, data_wr, rw, cmd_count, done, error
   );
endinterface

// File: rtl/ddr_stim_sequencer.sv
// DDR request stimulus sequencer: directed write/readback pairs or LFSR-random traffic.
// Optional ack watchdog enabled by defining SEQ_TIMEOUT_EN.
module ddr_stim_sequencer #(
   parameter int          ADDR_W      = 32,
   parameter int          DATA_W      = 64,
   parameter int          NUM_CMDS    = 16,
   parameter int          GAP_CYC     = 8,
   parameter int          MODE        = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h2000_a011,
   parameter logic [31:0] ADDR_STRIDE = 32'h40,
   parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFFF,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
   parameter int          TIMEOUT_CYC = 1024
) (
   input logic clock,
   input logic reset,
   ddr_stim_sequencer_if.master bus
);
   localparam int                REP       = DATA_W / ADDR_W;
   localparam int                RND_REP   = (DATA_W + 63) / 64;
   localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
   localparam logic [15:0]       NUM_LAST  = 16'(NUM_CMDS);
   localparam logic [7:0]        GAP_LOAD  = 8'(GAP_CYC - 1);
   localparam logic [ADDR_W-1:0] BASE_A    = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_STRIDE[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] MASK_A    = ADDR_MASK[ADDR_W-1:0];

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, GAP, DONE} state_t;

   state_t            state, state_n;
   logic              act_q, act_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic              rw_q, rw_n;
   logic [15:0]       count_q, count_n;
   logic              done_q, done_n;
   logic              error_q, error_n;
   logic [31:0]       lfsr_q, lfsr_n;
   logic [ADDR_W-1:0] pair_q, pair_n;
   logic              odd_q, odd_n;
   logic [7:0]        gap_q, gap_n;
`ifdef SEQ_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);
   logic [15:0]       wd_q, wd_n;
`endif

   // The LFSR advances before use, so each command is built from the stepped value.
   logic [31:0]         lfsr_step;
   logic [RND_REP*64-1:0] rnd_wide;
   assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
   assign rnd_wide  = {RND_REP{lfsr_step, ~lfsr_step}};

   // State and every registered output advance together on the clock edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         act_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         pair_q  <= BASE_A;
         odd_q   <= 1'b0;
         gap_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
         wd_q    <= '0;
`endif
      end else begin
         state   <= state_n;
         act_q   <= act_n;
         addr_q  <= addr_n;
         data_q  <= data_n;
         rw_q    <= rw_n;
         count_q <= count_n;
         done_q  <= done_n;
         error_q <= error_n;
         lfsr_q  <= lfsr_n;
         pair_q  <= pair_n;
         odd_q   <= odd_n;
         gap_q   <= gap_n;
`ifdef SEQ_TIMEOUT_EN
         wd_q    <= wd_n;
`endif
      end
   end

   // Next-state logic; act_cmd defaults low so every issue is a single-cycle pulse.
   always_comb begin
      state_n = state;
      act_n   = 1'b0;
      addr_n  = addr_q;
      data_n  = data_q;
      rw_n    = rw_q;
      count_n = count_q;
      done_n  = done_q;
      error_n = error_q;
      lfsr_n  = lfsr_q;
      pair_n  = pair_q;
      odd_n   = odd_q;
      gap_n   = gap_q;
`ifdef SEQ_TIMEOUT_EN
      wd_n    = '0;
`endif
      case (state)
         IDLE: begin
            if (bus.start) state_n = ISSUE;
         end
         ISSUE: begin
            if (!bus.dev_busy) begin
               act_n   = 1'b1;
               state_n = WAIT_ACK;
               if (MODE == 1) begin
                  lfsr_n = lfsr_step;
                  addr_n = lfsr_step[ADDR_W-1:0] & MASK_A;
                  rw_n   = lfsr_step[31];
                  data_n = rnd_wide[DATA_W-1:0];
               end else begin
                  // Write then read back the same address; stride only after the read.
                  addr_n = pair_q;
                  rw_n   = ~odd_q;
                  data_n = {REP{pair_q}};
                  odd_n  = ~odd_q;
                  if (odd_q) pair_n = pair_q + STRIDE_A;
               end
            end
         end
         WAIT_ACK: begin
            if (bus.next_cmd) begin
               count_n = count_q + 16'd1;
               if (count_q + 16'd1 == NUM_LAST) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else if (GAP_CYC == 0) begin
                  state_n = ISSUE;
               end else begin
                  state_n = GAP;
                  gap_n   = GAP_LOAD;
               end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wd_q == WD_LIMIT) begin
               error_n = 1'b1;
               done_n  = 1'b1;
               state_n = DONE;
            end else begin
               wd_n = wd_q + 16'd1;
            end
`endif
         end
         GAP: begin
            if (gap_q == 8'd0) state_n = ISSUE;
            else               gap_n   = gap_q - 8'd1;
         end
         DONE: begin
            if (bus.start) begin
               done_n  = 1'b0;
               count_n = '0;
               pair_n  = BASE_A;
               odd_n   = 1'b0;
               state_n = ISSUE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.act_cmd       = act_q;
   assign bus.physical_addr = addr_q;
   assign bus.data_wr       = data_q;
   assign bus.rw            = rw_q;
   assign bus.cmd_count     = count_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
endmodule

// File: tb/tb_ddr_stim_sequencer.sv
// Directed bench for ddr_stim_sequencer: three instances cover directed, random and zero-gap runs.
module tb_ddr_stim_sequencer;
   localparam logic [31:0] BASE   = 32'h2000_a011;
   localparam logic [31:0] STRIDE = 32'h40;
   localparam logic [31:0] RMASK  = 32'hFFFF_FFF0;
   localparam logic [31:0] SEED   = 32'hACE1_2468;

   logic       clock;
   logic       reset;
   logic [2:0] startIn;
   logic [2:0] busyIn;
   logic [2:0] nextIn;

   wire [2:0]  actObs;
   wire [2:0]  rwObs;
   wire [2:0]  doneObs;
   wire [2:0]  errorObs;
   wire [31:0] addrObs  [3];
   wire [63:0] dataObs  [3];
   wire [15:0] countObs [3];

   int checkCount = 0;
   int errorCount = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Unit 0: directed, 4 commands, gap 8. Unit 1: random, 100 commands, gap 2. Unit 2: directed, 3 commands, gap 0.
   for (genvar u = 0; u < 3; u++) begin : g_unit
      ddr_stim_sequencer_if bus ();
      ddr_stim_sequencer #(
         .ADDR_W      (32),
         .DATA_W      (64),
         .NUM_CMDS    (u == 0 ? 4 : (u == 1 ? 100 : 3)),
         .GAP_CYC     (u == 0 ? 8 : (u == 1 ? 2 : 0)),
         .MODE        (u == 1 ? 1 : 0),
         .BASE_ADDR   (BASE),
         .ADDR_STRIDE (STRIDE),
         .ADDR_MASK   (u == 1 ? RMASK : 32'hFFFF_FFFF),
         .LFSR_SEED   (SEED),
         .TIMEOUT_CYC (u == 0 ? 16 : 1024)
      ) dut (
         .clock (clock),
         .reset (reset),
         .bus   (bus)
      );
      assign bus.start    = startIn[u];
      assign bus.dev_busy = busyIn[u];
      assign bus.next_cmd = nextIn[u];
      assign actObs[u]    = bus.act_cmd;
      assign rwObs[u]     = bus.rw;
      assign doneObs[u]   = bus.done;
      assign errorObs[u]  = bus.error;
      assign addrObs[u]   = bus.physical_addr;
      assign dataObs[u]   = bus.data_wr;
      assign countObs[u]  = bus.cmd_count;
   end

   task automatic waitCycle();
      @(negedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int u, input logic s, input logic b, input logic n);
      startIn[u] = s;
      busyIn[u]  = b;
      nextIn[u]  = n;
   endtask

   // Returns the number of cycles until act_cmd is seen; an expired bound counts as a failure.
   task automatic waitForAct(input int u, input int limit, output int cycles);
      cycles = 0;
      while (actObs[u] !== 1'b1 && cycles < limit) begin
         waitCycle();
         cycles++;
      end
      checkOutput("act_seen", {63'd0, actObs[u]}, 64'd1);
   endtask

   // Checks the pulse is one cycle wide, then acks two cycles after act_cmd.
   task automatic ackCommand(input int u);
      waitCycle();
      checkOutput("act_pulse", {63'd0, actObs[u]}, 64'd0);
      waitCycle();
      nextIn[u] = 1'b1;
      waitCycle();
      nextIn[u] = 1'b0;
   endtask

   task automatic checkCommand(input int u, input logic [31:0] expAddr, input logic expRw, input logic [63:0] expData);
      checkOutput("addr", {32'd0, addrObs[u]}, {32'd0, expAddr});
      checkOutput("rw", {63'd0, rwObs[u]}, {63'd0, expRw});
      checkOutput("data", dataObs[u], expData);
   endtask

   function automatic logic [31:0] directedAddr(input int i);
      return BASE + 32'(i / 2) * STRIDE;
   endfunction

   function automatic logic [31:0] lfsrNext(input logic [31:0] x);
      logic lsb;
      lsb = x[0];
      x   = x >> 1;
      if (lsb) x = x ^ 32'h8020_0003;
      return x;
   endfunction

   initial begin
      int c;
      logic [31:0] a;
      logic [31:0] model;
      reset   = 1'b1;
      startIn = '0;
      busyIn  = '0;
      nextIn  = '0;
      waitCycle();
      waitCycle();
      reset = 1'b0;

      // Reset values.
      checkOutput("rst_act", {63'd0, actObs[0]}, 64'd0);
      checkOutput("rst_addr", {32'd0, addrObs[0]}, 64'd0);
      checkOutput("rst_data", dataObs[0], 64'd0);
      checkOutput("rst_rw", {63'd0, rwObs[0]}, 64'd0);
      checkOutput("rst_count", {48'd0, countObs[0]}, 64'd0);
      checkOutput("rst_done", {63'd0, doneObs[0]}, 64'd0);
      checkOutput("rst_error", {61'd0, errorObs}, 64'd0);

      // Directed write/readback pairs with ack 2 cycles after each act_cmd.
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      waitForAct(0, 20, c);
      checkOutput("start_latency", 64'(c), 64'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            waitForAct(0, 50, c);
            checkOutput("gap_len", 64'(c), 64'd9);
         end
         a = directedAddr(i);
         checkCommand(0, a, (i % 2) == 0, {a, a});
         ackCommand(0);
         checkOutput("cmd_count", {48'd0, countObs[0]}, 64'(i + 1));
         checkOutput("done_flag", {63'd0, doneObs[0]}, {63'd0, i == 3});
      end
      repeat (3) waitCycle();
      checkOutput("done_held", {63'd0, doneObs[0]}, 64'd1);
      checkOutput("no_act_done", {63'd0, actObs[0]}, 64'd0);

      // Restart from DONE while dev_busy stalls the first issue for 5 cycles.
      applyStimulus(0, 1'b1, 1'b1, 1'b0);
      waitCycle();
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      checkOutput("restart_done", {63'd0, doneObs[0]}, 64'd0);
      checkOutput("restart_count", {48'd0, countObs[0]}, 64'd0);
      for (int k = 0; k < 4; k++) begin
         checkOutput("busy_no_act", {63'd0, actObs[0]}, 64'd0);
         checkOutput("busy_addr_held", {32'd0, addrObs[0]}, 64'h2000_a051);
         waitCycle();
      end
      checkOutput("busy_no_act", {63'd0, actObs[0]}, 64'd0);
      busyIn[0] = 1'b0;
      waitCycle();
      checkOutput("busy_release_act", {63'd0, actObs[0]}, 64'd1);
      checkCommand(0, BASE, 1'b1, {BASE, BASE});
      ackCommand(0);
      waitForAct(0, 50, c);
      checkCommand(0, BASE, 1'b0, {BASE, BASE});

      // Reset while waiting for an ack, with next_cmd in the same cycle.
      reset     = 1'b1;
      nextIn[0] = 1'b1;
      waitCycle();
      reset     = 1'b0;
      nextIn[0] = 1'b0;
      checkOutput("midrst_act", {63'd0, actObs[0]}, 64'd0);
      checkOutput("midrst_addr", {32'd0, addrObs[0]}, 64'd0);
      checkOutput("midrst_data", dataObs[0], 64'd0);
      checkOutput("midrst_rw", {63'd0, rwObs[0]}, 64'd0);
      checkOutput("midrst_count", {48'd0, countObs[0]}, 64'd0);
      checkOutput("midrst_done", {63'd0, doneObs[0]}, 64'd0);
      repeat (4) begin
         waitCycle();
         checkOutput("idle_no_act", {63'd0, actObs[0]}, 64'd0);
      end
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      waitForAct(0, 20, c);
      checkOutput("idle_start_latency", 64'(c), 64'd1);
      checkCommand(0, BASE, 1'b1, {BASE, BASE});

      // Unit 0 now waits for an ack that never comes.
      repeat (15) waitCycle();
      checkOutput("wd_early", {63'd0, errorObs[0]}, 64'd0);
      waitCycle();
`ifdef SEQ_TIMEOUT_EN
      checkOutput("wd_error", {63'd0, errorObs[0]}, 64'd1);
      checkOutput("wd_done", {63'd0, doneObs[0]}, 64'd1);
      checkOutput("wd_count", {48'd0, countObs[0]}, 64'd0);
`else
      checkOutput("no_wd_error", {63'd0, errorObs[0]}, 64'd0);
      checkOutput("no_wd_done", {63'd0, doneObs[0]}, 64'd0);
`endif

      // Random traffic against a reference Galois LFSR.
      model = SEED;
      applyStimulus(1, 1'b1, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(1, 1'b0, 1'b0, 1'b0);
      waitForAct(1, 20, c);
      checkOutput("rnd_start_latency", 64'(c), 64'd1);
      for (int n = 0; n < 100; n++) begin
         if (n > 0) begin
            waitForAct(1, 50, c);
            checkOutput("rnd_gap_len", 64'(c), 64'd3);
         end
         model = lfsrNext(model);
         checkCommand(1, model & RMASK, model[31], {model, ~model});
         ackCommand(1);
         checkOutput("rnd_count", {48'd0, countObs[1]}, 64'(n + 1));
      end
      checkOutput("rnd_done", {63'd0, doneObs[1]}, 64'd1);

      // Zero gap with start held: odd run ends on a write, then restarts at BASE.
      applyStimulus(2, 1'b1, 1'b0, 1'b0);
      waitCycle();
      waitForAct(2, 20, c);
      checkOutput("g0_start_latency", 64'(c), 64'd1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            waitForAct(2, 20, c);
            checkOutput("g0_gap_len", 64'(c), 64'd1);
         end
         a = directedAddr(i);
         checkCommand(2, a, (i % 2) == 0, {a, a});
         ackCommand(2);
      end
      checkOutput("g0_done", {63'd0, doneObs[2]}, 64'd1);
      checkOutput("g0_count", {48'd0, countObs[2]}, 64'd3);
      waitCycle();
      checkOutput("g0_restart_done", {63'd0, doneObs[2]}, 64'd0);
      checkOutput("g0_restart_count", {48'd0, countObs[2]}, 64'd0);
      waitForAct(2, 20, c);
      checkOutput("g0_restart_latency", 64'(c), 64'd1);
      checkCommand(2, BASE, 1'b1, {BASE, BASE});
      applyStimulus(2, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
